// File: rtl/soc_mem_fabric_pkg.sv
// Shared definitions for the SoC data-memory fabric: FSM state encoding and
// fabric-wide constants.
package soc_mem_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } fabric_state_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  localparam int          MAX_SLV       = 8;

endpackage

// File: rtl/soc_mem_fabric_decoder.sv
// Combinational address decoder: (addr & mask) == base per slave, lowest
// index wins when windows overlap; miss when no slave matches.
module soc_mem_fabric_decoder #(
  parameter int unsigned           N_SLV    = 3,
  parameter logic [N_SLV*32-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*32-1:0]   SLV_MASK = '0
) (
  input  logic [31:0]      addr_i,
  output logic [N_SLV-1:0] hit_o,
  output logic             miss_o
);

  always_comb begin
    hit_o = '0;
    // Walk downward so the last match written is the lowest index.
    for (int i = int'(N_SLV) - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
      end
    end
    miss_o = ~|hit_o;
  end

endmodule

// File: rtl/soc_mem_fabric.sv
// Data-memory interconnect between the core's split rd/wr ports and N_SLV
// slaves. Optional ack timeout enabled by defining FABRIC_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a core access; decode and launch (write before read)
// ACCESS | slave request held until the selected slave acks (or timeout)
// DONE   | result cycle: read data valid, err_o pulse, stall released
module soc_mem_fabric
  import soc_mem_fabric_pkg::*;
#(
  parameter int unsigned         N_SLV     = 3,
  parameter logic [N_SLV*32-1:0] SLV_BASE  = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [N_SLV*32-1:0] SLV_MASK  = {32'h0000_F000, 32'h0000_F000, 32'h0000_F000},
  parameter int unsigned         TO_CYC    = 255,
  parameter logic [31:0]         ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd_req_i,
  input  logic [31:0]           mem_rd_addr_i,
  output logic [31:0]           mem_rd_data_o,
  input  logic                  mem_wr_req_i,
  input  logic [3:0]            mem_wr_sel_i,
  input  logic [31:0]           mem_wr_addr_i,
  input  logic [31:0]           mem_wr_data_i,
  output logic                  mem_stall_o,
  output logic [N_SLV-1:0]      slv_req_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_sel_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wdata_o,
  input  logic [N_SLV*32-1:0]   slv_rdata_i,
  input  logic [N_SLV-1:0]      slv_ack_i,
  output logic                  err_o
);

  if (N_SLV < 1 || N_SLV > MAX_SLV || TO_CYC < 1) begin : g_bad_param
    $error("soc_mem_fabric: illegal N_SLV or TO_CYC");
  end

  fabric_state_e    state_q, state_d;
  logic [N_SLV-1:0] req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             rd_pend_q, rd_pend_d;
  logic             stall_c;

  logic             wr_acc, rd_acc;
  logic [31:0]      dec_addr;
  logic [N_SLV-1:0] hit;
  logic             miss;
  logic             ack_sel;
  logic [31:0]      rdata_mux;
  logic             to_expired;

  // While a read is parked behind a write, the still-held write is masked.
  assign wr_acc   = mem_wr_req_i & (|mem_wr_sel_i) & ~rd_pend_q;
  assign rd_acc   = mem_rd_req_i;
  assign dec_addr = wr_acc ? mem_wr_addr_i : mem_rd_addr_i;

  soc_mem_fabric_decoder #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .addr_i (dec_addr),
    .hit_o  (hit),
    .miss_o (miss)
  );

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (req_q[i]) rdata_mux = rdata_mux | slv_rdata_i[i*32 +: 32];
    end
    ack_sel = |(slv_ack_i & req_q);
  end

`ifdef FABRIC_TIMEOUT_EN
  localparam int unsigned TO_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_expired = (to_cnt_q == '0);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ST_IDLE) begin
      to_cnt_d = TO_W'(TO_CYC - 1);
    end else if (state_q == ST_ACCESS && !to_expired) begin
      to_cnt_d = to_cnt_q - TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  assign to_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    rd_pend_d = rd_pend_q;
    stall_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc || rd_acc) begin
          stall_c   = 1'b1;
          rd_pend_d = wr_acc & rd_acc;
          if (miss) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            if (!wr_acc) rdata_d = ERR_RDATA;
          end else begin
            state_d = ST_ACCESS;
            req_d   = hit;
            we_d    = wr_acc;
            sel_d   = wr_acc ? mem_wr_sel_i : 4'b0;
            addr_d  = dec_addr;
            wdata_d = wr_acc ? mem_wr_data_i : 32'h0;
          end
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        if (ack_sel) begin
          req_d   = '0;
          state_d = ST_DONE;
          if (!we_q) rdata_d = rdata_mux;
        end else if (to_expired) begin
          req_d   = '0;
          state_d = ST_DONE;
          err_d   = 1'b1;
          if (!we_q) rdata_d = ERR_RDATA;
        end
      end
      ST_DONE: begin
        stall_c = rd_pend_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= 4'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign mem_stall_o   = stall_c & rst;
  assign mem_rd_data_o = rdata_q;
  assign slv_req_o     = req_q;
  assign slv_we_o      = we_q;
  assign slv_sel_o     = sel_q;
  assign slv_addr_o    = addr_q;
  assign slv_wdata_o   = wdata_q;
  assign err_o         = err_q;

endmodule
